hazard_stall_ctrl: RTL and testbench

//  Responder side of the hazard request interface: takes load-use and branch/jump stall requests

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/hazard_perf_counters.sv | 30 +++
 rtl/hazard_stall_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the hazard/stall controller.
// The optional HAZARD_PERF_CNT_EN build uses sat_inc32 for its event counters.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      HZ_IDLE,
      HZ_LU_STALL,
      HZ_BR_WAIT,
      HZ_HALTED
   } hz_state_t;

   localparam int LU_CNT_W = 3;
   localparam int BR_CNT_W = 4;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating stall/flush event counters for the hazard controller.
// Present only when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counters
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        lu_inc,
   input  logic        br_inc,
   input  logic        fl_inc,
   output logic [31:0] lu_stall_cyc,
   output logic [31:0] br_stall_cyc,
   output logic [31:0] flush_cnt
);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         lu_stall_cyc <= '0;
         br_stall_cyc <= '0;
         flush_cnt    <= '0;
      end else begin
         if (lu_inc) lu_stall_cyc <= sat_inc32(lu_stall_cyc);
         if (br_inc) br_stall_cyc <= sat_inc32(br_stall_cyc);
         if (fl_inc) flush_cnt    <= sat_inc32(flush_cnt);
      end
   end

endmodule
`endif

// File: rtl/hazard_stall_ctrl.sv
// Responder for hazard-unit stall requests: sequences load-use bubbles and branch waits,
// drives PC/latch enables and flushes. HAZARD_PERF_CNT_EN adds saturating perf counters.
module hazard_stall_ctrl
   import cpu_types_pkg::*;
#(
   parameter int LU_STALL_CYCLES = 2,
   parameter int BR_WAIT_MAX     = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        load_use,
   input  logic        jump_use,
   input  logic        ihit,
   input  logic        dmem_req,
   input  logic        dhit,
   input  logic        br_resolved,
   input  logic        br_taken,
   input  logic        halt,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        lu_done,
   output logic        ju_done,
   output logic        br_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] lu_stall_cyc,
   output logic [31:0] br_stall_cyc,
   output logic [31:0] flush_cnt
`endif
);

   localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LU_STALL_CYCLES);
   localparam logic [LU_CNT_W-1:0] LU_ONE  = LU_CNT_W'(1);
   localparam logic [BR_CNT_W-1:0] BR_LAST = BR_CNT_W'(BR_WAIT_MAX - 1);
   localparam logic [BR_CNT_W-1:0] BR_ONE  = BR_CNT_W'(1);

   hz_state_t           state, state_n;
   logic [LU_CNT_W-1:0] cnt, cnt_n;
   logic [BR_CNT_W-1:0] wcnt, wcnt_n;
   logic                lu_pend, lu_pend_n;
   logic                ju_pend, ju_pend_n;
   logic                to_fire;
   logic                adv, lu_req, ju_req;

   // A missing icache hit or an outstanding data access freezes the whole pipe.
   assign adv    = ihit & ~(dmem_req & ~dhit);
   assign lu_req = load_use | lu_pend;
   assign ju_req = jump_use | ju_pend;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= HZ_IDLE;
         cnt        <= '0;
         wcnt       <= '0;
         lu_pend    <= 1'b0;
         ju_pend    <= 1'b0;
         br_timeout <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         wcnt    <= wcnt_n;
         lu_pend <= lu_pend_n;
         ju_pend <= ju_pend_n;
         if (to_fire) br_timeout <= 1'b1;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      wcnt_n      = wcnt;
      lu_pend_n   = lu_pend;
      ju_pend_n   = ju_pend;
      to_fire     = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      lu_done     = 1'b0;
      ju_done     = 1'b0;

      if (halt) begin
         state_n = HZ_HALTED;
      end else begin
         case (state)
            HZ_IDLE: begin
               pc_en    = adv;
               ifid_en  = adv;
               idex_en  = adv;
               exmem_en = adv;
               memwb_en = adv;
               if (adv) begin
                  lu_pend_n = 1'b0;
                  ju_pend_n = 1'b0;
                  if (lu_req) begin
                     state_n   = HZ_LU_STALL;
                     cnt_n     = LU_INIT;
                     ju_pend_n = ju_req;  // branch waits behind the load-use bubbles
                  end else if (ju_req) begin
                     state_n = HZ_BR_WAIT;
                     wcnt_n  = '0;
                  end
               end else begin
                  // Requests may be single-cycle; hold them across the freeze.
                  lu_pend_n = lu_req;
                  ju_pend_n = ju_req;
               end
            end

            HZ_LU_STALL: begin
               idex_en    = adv;
               exmem_en   = adv;
               memwb_en   = adv;
               idex_flush = adv;
               if (adv) begin
                  if (cnt <= LU_ONE) begin
                     cnt_n   = '0;
                     lu_done = 1'b1;
                     state_n = HZ_IDLE;
                  end else begin
                     cnt_n = cnt - LU_ONE;
                  end
               end
            end

            HZ_BR_WAIT: begin
               idex_en    = adv;
               exmem_en   = adv;
               memwb_en   = adv;
               ifid_flush = adv;
               if (adv) begin
                  if (br_resolved) begin
                     pc_en       = 1'b1;
                     ju_done     = 1'b1;
                     idex_flush  = br_taken;
                     exmem_flush = br_taken;
                     state_n     = HZ_IDLE;
                  end else begin
                     wcnt_n = (wcnt == '1) ? wcnt : wcnt + BR_ONE;
                     if (wcnt >= BR_LAST) begin
                        // Watchdog: retire the request so fetch is not held forever.
                        to_fire = 1'b1;
                        ju_done = 1'b1;
                        state_n = HZ_IDLE;
                     end
                  end
               end
            end

            HZ_HALTED: begin
            end
         endcase
      end

      if (!nRST) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         lu_done     = 1'b0;
         ju_done     = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic lu_inc, br_inc, fl_inc;

   assign lu_inc = adv & ~halt & (state == HZ_LU_STALL);
   assign br_inc = adv & ~halt & (state == HZ_BR_WAIT);
   assign fl_inc = br_inc & br_resolved & br_taken;

   hazard_perf_counters u_perf (
      .CLK          (CLK),
      .nRST         (nRST),
      .lu_inc       (lu_inc),
      .br_inc       (br_inc),
      .fl_inc       (fl_inc),
      .lu_stall_cyc (lu_stall_cyc),
      .br_stall_cyc (br_stall_cyc),
      .flush_cnt    (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, directed corner sequences, and random
// stimulus checked against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

   typedef struct packed {
      logic nrst, load_use, jump_use, ihit, dmem_req, dhit, br_resolved, br_taken, halt;
   } in_t;

   typedef struct packed {
      logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
      logic ifid_flush, idex_flush, exmem_flush;
      logic lu_done, ju_done, br_timeout;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   //                                en    flush done to
   localparam out_t O_RUN  = 11'b11111_000_00_0;
   localparam out_t O_FRZ  = 11'b00000_000_00_0;
   localparam out_t O_LU   = 11'b00111_010_00_0;
   localparam out_t O_LUD  = 11'b00111_010_10_0;
   localparam out_t O_BR   = 11'b00111_100_00_0;
   localparam out_t O_BRT  = 11'b10111_111_01_0;
   localparam out_t O_BRN  = 11'b10111_100_01_0;
   localparam out_t O_BRTO = 11'b00111_100_01_0;
   localparam out_t O_RST  = 11'b00000_111_00_0;
   localparam out_t O_TO   = 11'b00000_000_00_1;

   localparam int LU_N = 2;
   localparam int BR_N = 8;

   logic CLK = 1'b0;
   logic nRST, load_use, jump_use, ihit, dmem_req, dhit, br_resolved, br_taken, halt;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, lu_done, ju_done, br_timeout;

   int total = 0;
   int bad   = 0;

   // model state
   bit m_halted, m_in_br, m_lu_p, m_ju_p, m_to;
   int m_lu_left, m_br_cnt;

   vec_t tq[$];

   always #5 CLK = ~CLK;

   hazard_stall_ctrl #(.LU_STALL_CYCLES(LU_N), .BR_WAIT_MAX(BR_N)) dut (
      .CLK(CLK), .nRST(nRST), .load_use(load_use), .jump_use(jump_use), .ihit(ihit),
      .dmem_req(dmem_req), .dhit(dhit), .br_resolved(br_resolved), .br_taken(br_taken),
      .halt(halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .lu_done(lu_done), .ju_done(ju_done), .br_timeout(br_timeout)
   );

   function automatic in_t mk_in(bit lu, bit ju, bit res, bit tk, bit frz);
      in_t v;
      v = '0;
      v.nrst = 1'b1; v.load_use = lu; v.jump_use = ju; v.ihit = 1'b1;
      v.dmem_req = frz; v.dhit = 1'b0; v.br_resolved = res; v.br_taken = tk;
      return v;
   endfunction

   function automatic in_t in_rst();
      in_t v;
      v = mk_in(0, 0, 0, 0, 0);
      v.nrst = 1'b0;
      return v;
   endfunction

   function automatic in_t in_halt();
      in_t v;
      v = mk_in(0, 0, 0, 0, 0);
      v.halt = 1'b1;
      return v;
   endfunction

   task automatic drive(input in_t v);
      nRST = v.nrst; load_use = v.load_use; jump_use = v.jump_use; ihit = v.ihit;
      dmem_req = v.dmem_req; dhit = v.dhit; br_resolved = v.br_resolved;
      br_taken = v.br_taken; halt = v.halt;
   endtask

   // Behavioural model: outputs for this cycle, then advance to the next edge.
   task automatic model(input in_t v, output out_t e);
      bit adv, lu, ju;
      adv = v.ihit && !(v.dmem_req && !v.dhit);
      e = '0;
      e.br_timeout = m_to;
      if (!v.nrst) begin
         e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
         m_halted = 0; m_in_br = 0; m_lu_p = 0; m_ju_p = 0; m_to = 0;
         m_lu_left = 0; m_br_cnt = 0;
         return;
      end
      if (m_halted || v.halt) begin
         m_halted = 1;
         return;
      end
      lu = v.load_use || m_lu_p;
      ju = v.jump_use || m_ju_p;
      if (m_lu_left > 0) begin
         e.idex_en = adv; e.exmem_en = adv; e.memwb_en = adv; e.idex_flush = adv;
         if (adv) begin
            m_lu_left--;
            if (m_lu_left == 0) e.lu_done = 1;
         end
      end else if (m_in_br) begin
         e.idex_en = adv; e.exmem_en = adv; e.memwb_en = adv; e.ifid_flush = adv;
         if (adv && v.br_resolved) begin
            e.pc_en = 1; e.ju_done = 1;
            e.idex_flush = v.br_taken; e.exmem_flush = v.br_taken;
            m_in_br = 0;
         end else if (adv) begin
            m_br_cnt++;
            if (m_br_cnt == BR_N) begin
               e.ju_done = 1; m_to = 1; m_in_br = 0;
            end
         end
      end else begin
         e.pc_en = adv; e.ifid_en = adv; e.idex_en = adv; e.exmem_en = adv; e.memwb_en = adv;
         if (adv) begin
            m_lu_p = 0;
            m_ju_p = 0;
            if (lu) begin
               m_lu_left = LU_N;
               m_ju_p = ju;
            end else if (ju) begin
               m_in_br = 1;
               m_br_cnt = 0;
            end
         end else begin
            m_lu_p = lu;
            m_ju_p = ju;
         end
      end
   endtask

   task automatic cyc(input in_t v, input bit use_ref, input out_t ref_o, input string nm);
      out_t e, a;
      @(negedge CLK);
      drive(v);
      #2;
      model(v, e);
      a = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           exmem_flush, lu_done, ju_done, br_timeout};
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s model: got %b want %b", nm, a, e);
      end
      if (use_ref) begin
         total++;
         if (a !== ref_o) begin
            bad++;
            $display("FAIL %s vector: got %b want %b", nm, a, ref_o);
         end
      end
   endtask

   task automatic add(input in_t v, input out_t o);
      tq.push_back('{v, o});
   endtask

   initial begin
      in_t v;
      drive(in_rst());
      @(posedge CLK);
      cyc(in_rst(), 1, O_RST, "reset");

      // single load-use
      add(mk_in(0,0,0,0,0), O_RUN);
      add(mk_in(1,0,0,0,0), O_RUN);
      add(mk_in(0,0,0,0,0), O_LU);
      add(mk_in(0,0,0,0,0), O_LUD);
      add(mk_in(0,0,0,0,0), O_RUN);
      // load-use with a 3-cycle dcache miss between the bubbles
      add(mk_in(1,0,0,0,0), O_RUN);
      add(mk_in(0,0,0,0,0), O_LU);
      add(mk_in(0,0,0,0,1), O_FRZ);
      add(mk_in(0,0,0,0,1), O_FRZ);
      add(mk_in(0,0,0,0,1), O_FRZ);
      add(mk_in(0,0,0,0,0), O_LUD);
      add(mk_in(0,0,0,0,0), O_RUN);
      // taken branch after two wait cycles
      add(mk_in(0,1,0,0,0), O_RUN);
      add(mk_in(0,0,0,0,0), O_BR);
      add(mk_in(0,0,0,0,0), O_BR);
      add(mk_in(0,0,1,1,0), O_BRT);
      add(mk_in(0,0,0,0,0), O_RUN);
      // not-taken branch resolved immediately
      add(mk_in(0,1,0,0,0), O_RUN);
      add(mk_in(0,0,1,0,0), O_BRN);
      add(mk_in(0,0,0,0,0), O_RUN);
      // simultaneous requests: load-use first, then the branch
      add(mk_in(1,1,0,0,0), O_RUN);
      add(mk_in(0,0,0,0,0), O_LU);
      add(mk_in(0,0,0,0,0), O_LUD);
      add(mk_in(0,0,0,0,0), O_RUN);
      add(mk_in(0,0,0,0,0), O_BR);
      add(mk_in(0,0,1,1,0), O_BRT);
      add(mk_in(0,0,0,0,0), O_RUN);
      // request pulse during a freeze is taken on the next advance
      add(mk_in(1,0,0,0,1), O_FRZ);
      add(mk_in(0,0,0,0,0), O_RUN);
      add(mk_in(0,0,0,0,0), O_LU);
      add(mk_in(0,0,0,0,0), O_LUD);
      add(mk_in(0,0,0,0,0), O_RUN);

      for (int k = 0; k < tq.size(); k++)
         cyc(tq[k].i, 1, tq[k].o, $sformatf("tab%0d", k));

      // watchdog: 8 advancing wait cycles with a freeze in between
      cyc(mk_in(0,1,0,0,0), 1, O_RUN, "wd_entry");
      for (int k = 0; k < 3; k++) cyc(mk_in(0,0,0,0,0), 1, O_BR, "wd_wait_a");
      for (int k = 0; k < 2; k++) cyc(mk_in(0,0,0,0,1), 1, O_FRZ, "wd_frz");
      for (int k = 0; k < 4; k++) cyc(mk_in(0,0,0,0,0), 1, O_BR, "wd_wait_b");
      cyc(mk_in(0,0,0,0,0), 1, O_BRTO, "wd_fire");
      for (int k = 0; k < 3; k++) cyc(mk_in(0,0,0,0,0), 1, O_RUN | O_TO, "wd_sticky");
      cyc(in_rst(), 1, O_RST | O_TO, "wd_rst");
      cyc(mk_in(0,0,0,0,0), 1, O_RUN, "wd_cleared");

      // reset mid-stall abandons the request
      cyc(mk_in(1,0,0,0,0), 1, O_RUN, "rs_entry");
      cyc(mk_in(0,0,0,0,0), 1, O_LU, "rs_bubble");
      cyc(in_rst(), 1, O_RST, "rs_rst");
      cyc(mk_in(0,0,0,0,0), 1, O_RUN, "rs_idle0");
      cyc(mk_in(0,0,0,0,0), 1, O_RUN, "rs_idle1");

      // halt freezes everything until reset
      cyc(in_halt(), 1, O_FRZ, "halt");
      cyc(mk_in(0,0,0,0,0), 1, O_FRZ, "halted0");
      cyc(mk_in(1,0,0,0,0), 1, O_FRZ, "halted_lu");
      cyc(mk_in(0,1,1,1,0), 1, O_FRZ, "halted_br");
      cyc(in_rst(), 1, O_RST, "halt_rst");
      cyc(mk_in(0,0,0,0,0), 1, O_RUN, "halt_exit");

      for (int n = 0; n < 3000; n++) begin
         v.nrst        = ($urandom_range(0, 59) != 0);
         v.load_use    = ($urandom_range(0, 5) == 0);
         v.jump_use    = ($urandom_range(0, 5) == 0);
         v.ihit        = ($urandom_range(0, 7) != 0);
         v.dmem_req    = 1'($urandom_range(0, 1));
         v.dhit        = ($urandom_range(0, 2) != 0);
         v.br_resolved = ($urandom_range(0, 9) == 0);
         v.br_taken    = 1'($urandom_range(0, 1));
         v.halt        = ($urandom_range(0, 299) == 0);
         cyc(v, 0, O_FRZ, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
